// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small circular byte FIFO.
// Queued bytes go out back-to-back; a frame is exactly 10*g_Clks_Per_Bit cycles.
module uart_tx_fifo #(
  parameter int g_Clks_Per_Bit    = 10417,
  parameter int g_Fifo_Addr_Width = 2
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_TX_DV,
  input  logic [7:0]                 i_TX_Byte,
  output logic                       o_TX_Ready,
  output logic                       o_TX_Serial,
  output logic                       o_TX_Active,
  output logic                       o_TX_Done,
  output logic                       o_Overflow,
  output logic [g_Fifo_Addr_Width:0] o_Fifo_Count
);

  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (low)
  // DATA  | data bits 0..7 from the shift register
  // STOP  | stop bit (high); chains into START if more bytes are queued
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DEPTH = 2 ** g_Fifo_Addr_Width;
  localparam int CW    = (g_Clks_Per_Bit > 1) ? $clog2(g_Clks_Per_Bit) : 1;
  localparam logic [g_Fifo_Addr_Width:0] FULL = (g_Fifo_Addr_Width + 1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(g_Clks_Per_Bit - 1);

  state_t                       state, state_nxt;
  logic [CW-1:0]                clk_cnt, clk_cnt_nxt;
  logic [2:0]                   bit_idx, bit_idx_nxt;
  logic [7:0]                   shift;
  logic [7:0]                   mem [DEPTH];
  logic [g_Fifo_Addr_Width-1:0] wr_ptr, rd_ptr;
  logic [g_Fifo_Addr_Width:0]   count;
  logic                         bit_end, pop, push;

  assign bit_end      = (clk_cnt == BIT_LAST);
  assign o_TX_Ready   = (count < FULL);
  assign push         = i_TX_DV && o_TX_Ready;
  assign o_Overflow   = i_TX_DV && !o_TX_Ready;
  assign o_Fifo_Count = count;

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    o_TX_Serial = 1'b1;
    o_TX_Active = 1'b1;
    o_TX_Done   = 1'b0;
    case (state)
      IDLE: begin
        o_TX_Active = 1'b0;
        clk_cnt_nxt = '0;
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        o_TX_Serial = 1'b0;
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        o_TX_Serial = shift[bit_idx];
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          o_TX_Done   = 1'b1;
          clk_cnt_nxt = '0;
          // chain straight into the next frame so there is no idle gap
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr] <= i_TX_Byte;
  end

endmodule
